regfile_access_ctrl: RTL and testbench

- Initiator side of the 8x12-bit two-read/one-write register file interface.
- Accepts decoded instructions, drives the register-file read addresses, and registers the operand pair toward the ALU stage.
- Drives the write port from the writeback stage.
- Keeps an 8-bit pending-write scoreboard with writeback bypass, so an instruction never issues with a stale operand.

---
 rtl/regfile_access_ctrl_if.sv | 45 ++++
 rtl/regfile_access_ctrl.sv | 68 ++++++
 tb/tb_regfile_access_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: issue, operand, writeback and register-file signal bundle
interface regfile_access_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);
  logic                    issue_valid;
  logic                    issue_ready;
  logic [ADDR_W-1:0]       issue_src1;
  logic [ADDR_W-1:0]       issue_src2;
  logic [ADDR_W-1:0]       issue_dst;
  logic                    issue_wr;
  logic                    op_valid;
  logic                    op_ready;
  logic [DATA_W-1:0]       op_a;
  logic [DATA_W-1:0]       op_b;
  logic [ADDR_W-1:0]       op_dst;
  logic                    op_wr;
  logic                    wb_valid;
  logic [ADDR_W-1:0]       wb_addr;
  logic [DATA_W-1:0]       wb_data;
  logic [ADDR_W-1:0]       rf_read_addr1;
  logic [ADDR_W-1:0]       rf_read_addr2;
  logic [DATA_W-1:0]       rf_read_out1;
  logic [DATA_W-1:0]       rf_read_out2;
  logic [ADDR_W-1:0]       rf_write_addr;
  logic [DATA_W-1:0]       rf_data_in;
  logic                    rf_write_en;
  logic [(2**ADDR_W)-1:0]  pending;
  logic [CNT_W-1:0]        stall_cnt;
  modport master (
    input  issue_valid, issue_src1, issue_src2, issue_dst, issue_wr,
    input  op_ready, wb_valid, wb_addr, wb_data, rf_read_out1, rf_read_out2,
    output issue_ready, op_valid, op_a, op_b, op_dst, op_wr,
    output rf_read_addr1, rf_read_addr2, rf_write_addr, rf_data_in, rf_write_en,
    output pending, stall_cnt
  );
  modport slave (
    output issue_valid, issue_src1, issue_src2, issue_dst, issue_wr,
    output op_ready, wb_valid, wb_addr, wb_data, rf_read_out1, rf_read_out2,
    input  issue_ready, op_valid, op_a, op_b, op_dst, op_wr,
    input  rf_read_addr1, rf_read_addr2, rf_write_addr, rf_data_in, rf_write_en,
    input  pending, stall_cnt
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: register-file initiator with pending-write scoreboard, writeback bypass and operand slot
module regfile_access_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input logic                  clk,
  input logic                  reset,
  regfile_access_ctrl_if.master bus
);
  localparam int NREG = 2**ADDR_W;
  typedef enum logic {EMPTY, FULL} slot_e;
  slot_e             state_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic [ADDR_W-1:0] op_dst_q;
  logic              op_wr_q;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              byp1, byp2, hazard, slot_free, ready, accept;
  assign byp1      = bus.wb_valid && bus.wb_addr == bus.issue_src1;
  assign byp2      = bus.wb_valid && bus.wb_addr == bus.issue_src2;
  assign hazard    = (pending_q[bus.issue_src1] && !byp1) || (pending_q[bus.issue_src2] && !byp2);
  assign slot_free = state_q == EMPTY || bus.op_ready;
  assign ready     = slot_free && !hazard;
  assign accept    = bus.issue_valid && ready;
  // a new writer to the same register outranks a writeback retiring the older one
  always_comb
    for (int i = 0; i < NREG; i++)
      pending_d[i] = (accept && bus.issue_wr && bus.issue_dst == ADDR_W'(i)) ? 1'b1 :
                     (bus.wb_valid && bus.wb_addr == ADDR_W'(i)) ? 1'b0 : pending_q[i];
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_dst_q    <= '0;
      op_wr_q     <= 1'b0;
      pending_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      if (bus.issue_valid && !ready && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (accept) begin
        state_q  <= FULL;
        op_a_q   <= byp1 ? bus.wb_data : bus.rf_read_out1;
        op_b_q   <= byp2 ? bus.wb_data : bus.rf_read_out2;
        op_dst_q <= bus.issue_dst;
        op_wr_q  <= bus.issue_wr;
      end else if (bus.op_ready) begin
        state_q <= EMPTY;
      end
    end
  end
  assign bus.issue_ready   = ready;
  assign bus.op_valid      = state_q == FULL;
  assign bus.op_a          = op_a_q;
  assign bus.op_b          = op_b_q;
  assign bus.op_dst        = op_dst_q;
  assign bus.op_wr         = op_wr_q;
  assign bus.rf_read_addr1 = bus.issue_src1;
  assign bus.rf_read_addr2 = bus.issue_src2;
  assign bus.rf_write_addr = bus.wb_addr;
  assign bus.rf_data_in    = bus.wb_data;
  assign bus.rf_write_en   = bus.wb_valid && !reset;
  assign bus.pending       = pending_q;
  assign bus.stall_cnt     = stall_cnt_q;
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed plus random checks against a behavioural register-file model
module tb_regfile_access_ctrl;
  localparam int DW = 12, AW = 3, CW = 8, NR = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  regfile_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus();
  regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [DW-1:0] rf [NR];
  always @(posedge clk) if (bus.rf_write_en) rf[bus.rf_write_addr] <= bus.rf_data_in;
  assign bus.rf_read_out1 = rf[bus.rf_read_addr1];
  assign bus.rf_read_out2 = rf[bus.rf_read_addr2];
  logic [DW-1:0] m_rf [NR];
  logic [NR-1:0] m_pend = '0;
  logic          m_val = 1'b0, m_wr = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [AW-1:0] m_dst = '0;
  int            m_stall = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit avail(logic [AW-1:0] s);
    return !m_pend[s] || (bus.wb_valid && bus.wb_addr == s);
  endfunction
  function automatic logic [DW-1:0] value_of(logic [AW-1:0] s);
    return (bus.wb_valid && bus.wb_addr == s) ? bus.wb_data : m_rf[s];
  endfunction
  task automatic cyc();
    bit rdy_exp, acc;
    #2;
    rdy_exp = (!m_val || bus.op_ready) && avail(bus.issue_src1) && avail(bus.issue_src2);
    acc = bus.issue_valid && rdy_exp;
    chk("issue_ready", bus.issue_ready, rdy_exp);
    chk("rf_write_en", bus.rf_write_en, bus.wb_valid && !reset);
    chk("op_valid", bus.op_valid, m_val);
    chk("op_a", bus.op_a, m_a);
    chk("op_b", bus.op_b, m_b);
    chk("op_dst", bus.op_dst, m_dst);
    chk("op_wr", bus.op_wr, m_wr);
    chk("pending", bus.pending, m_pend);
    chk("stall_cnt", bus.stall_cnt, m_stall);
    if (reset) begin
      {m_val, m_wr, m_a, m_b, m_dst, m_pend} = '0;
      m_stall = 0;
    end else begin
      if (bus.issue_valid && !rdy_exp && m_stall < 255) m_stall++;
      if (acc) begin
        m_val = 1'b1;
        m_a = value_of(bus.issue_src1);
        m_b = value_of(bus.issue_src2);
        m_dst = bus.issue_dst;
        m_wr = bus.issue_wr;
      end else if (bus.op_ready) m_val = 1'b0;
      if (bus.wb_valid) begin
        m_pend[bus.wb_addr] = 1'b0;
        m_rf[bus.wb_addr] = bus.wb_data;
      end
      if (acc && bus.issue_wr) m_pend[bus.issue_dst] = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) chk($sformatf("rf[%0d]", i), rf[i], m_rf[i]);
  endtask
  task automatic drv(bit iv, int s1, int s2, int d, bit w, bit rdy, bit wv, int wa, int wd);
    bus.issue_valid = iv;
    bus.issue_src1 = AW'(s1);
    bus.issue_src2 = AW'(s2);
    bus.issue_dst = AW'(d);
    bus.issue_wr = w;
    bus.op_ready = rdy;
    bus.wb_valid = wv;
    bus.wb_addr = AW'(wa);
    bus.wb_data = DW'(wd);
    cyc();
  endtask
  initial begin
    bus.issue_valid = 0; bus.issue_src1 = 0; bus.issue_src2 = 0; bus.issue_dst = 0;
    bus.issue_wr = 0; bus.op_ready = 0; bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NR; i++) drv(0, 0, 0, 0, 0, 1, 1, i, i * 'h111);
    // basic issue with values written through the writeback port
    drv(0, 0, 0, 0, 0, 1, 1, 2, 'h0A5);
    drv(0, 0, 0, 0, 0, 1, 1, 5, 'h3C0);
    drv(1, 2, 5, 1, 1, 1, 0, 0, 0);
    chk("tp1_op_a", bus.op_a, 'h0A5);
    chk("tp1_op_b", bus.op_b, 'h3C0);
    chk("tp1_op_dst", bus.op_dst, 1);
    chk("tp1_pending", bus.pending, 'h02);
    // RAW stall then bypass release
    repeat (3) drv(1, 1, 0, 3, 0, 1, 0, 0, 0);
    chk("tp2_stall_cnt", bus.stall_cnt, 3);
    drv(1, 1, 0, 3, 0, 1, 1, 1, 'h7FF);
    chk("tp2_op_a", bus.op_a, 'h7FF);
    chk("tp2_op_valid", bus.op_valid, 1);
    chk("tp2_pending", bus.pending, 'h00);
    // backpressure hold, then one bundle per cycle
    repeat (4) drv(1, 2, 5, 6, 0, 0, 0, 0, 0);
    chk("tp3_hold_a", bus.op_a, 'h7FF);
    chk("tp3_hold_dst", bus.op_dst, 3);
    chk("tp3_ready", bus.issue_ready, 0);
    for (int k = 0; k < 4; k++) begin
      drv(1, k, 7 - k, k + 4, 0, 1, 0, 0, 0);
      chk("tp3_stream_dst", bus.op_dst, k + 4);
      chk("tp3_stream_valid", bus.op_valid, 1);
    end
    // same-cycle set and clear of one scoreboard bit
    drv(1, 0, 0, 4, 1, 1, 0, 0, 0);
    drv(1, 0, 0, 4, 1, 1, 1, 4, 'h123);
    chk("tp4_pending", bus.pending, 'h10);
    chk("tp4_rf4", rf[4], 'h123);
    // reset with a bundle in flight and a writeback pending
    drv(1, 0, 0, 7, 1, 1, 0, 0, 0);
    chk("tp5_pre_pending", bus.pending, 'h90);
    reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 1, 3, 'hABC);
    reset = 1'b0;
    chk("tp5_op_valid", bus.op_valid, 0);
    chk("tp5_pending", bus.pending, 0);
    chk("tp5_rf3", rf[3], 'h333);
    // stall counter saturation
    drv(1, 0, 0, 1, 1, 1, 0, 0, 0);
    repeat (300) drv(1, 1, 1, 2, 0, 1, 0, 0, 0);
    chk("tp6_stall_sat", bus.stall_cnt, 255);
    drv(0, 0, 0, 0, 0, 1, 1, 1, 'h055);
    repeat (600) begin
      reset = ($urandom_range(0, 39) == 0);
      drv($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 9) < 7, $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, 4095));
    end
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
